// File: rtl/wave_dds_gen.sv
// Phase-accumulator waveform generator: saw / falling ramp / triangle / square.
// Two-stage pipe (accumulator, then shaper) with double-buffered tuning config.
module wave_dds_gen #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic               load,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic [1:0]         mode,
  input  logic [OUT_W-1:0]   duty,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wave_valid,
  output logic               wrap
);

  localparam logic [1:0] MODE_SAW  = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_SQR  = 2'b11;

  localparam logic [OUT_W-1:0] DUTY_RST = OUT_W'(1) << (OUT_W-1);

  typedef struct packed {
    logic [PHASE_W-1:0] tune;
    logic [1:0]         mode;
    logic [OUT_W-1:0]   duty;
  } cfg_t;

  // accumulator stage
  logic [PHASE_W-1:0] r_acc;
  logic               r_wrap;
  logic               r_en_d;

  // config double buffer
  cfg_t               r_act;
  cfg_t               r_pend;
  logic               r_pend_vld;

  // shaper stage
  logic [OUT_W-1:0]   r_wave;
  logic               r_valid;

  logic [PHASE_W-1:0] w_sum;
  logic               w_carry;
  logic               w_apply;
  logic               w_load_direct;
  cfg_t               w_new_cfg;
  logic [OUT_W-1:0]   w_p;
  logic [OUT_W-1:0]   w_p_dbl;
  logic [OUT_W-1:0]   w_shape;

  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_act.tune};

  // Config swaps only at phase-continuous points: an overflow or a sync.
  assign w_apply       = sync | (en & w_carry);
  assign w_load_direct = load & (~en | w_apply);
  assign w_new_cfg     = '{tune: tune_word, mode: mode, duty: duty};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= en;
      if (sync) begin
        r_acc  <= '0;
        r_wrap <= 1'b0;
      end else if (en) begin
        r_acc  <= w_sum;
        r_wrap <= w_carry;
      end else begin
        r_wrap <= 1'b0;
      end
    end
  end

  // A load landing on an apply edge goes straight to active; older pending is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act      <= '{tune: '0, mode: MODE_SAW, duty: DUTY_RST};
      r_pend     <= '{tune: '0, mode: MODE_SAW, duty: DUTY_RST};
      r_pend_vld <= 1'b0;
    end else if (w_load_direct) begin
      r_act      <= w_new_cfg;
      r_pend_vld <= 1'b0;
    end else if (load) begin
      r_pend     <= w_new_cfg;
      r_pend_vld <= 1'b1;
    end else if (w_apply && r_pend_vld) begin
      r_act      <= r_pend;
      r_pend_vld <= 1'b0;
    end
  end

  assign w_p     = r_acc[PHASE_W-1 -: OUT_W];
  assign w_p_dbl = {w_p[OUT_W-2:0], 1'b0};

  always_comb begin
    w_shape = '0;
    case (r_act.mode)
      MODE_SAW:  w_shape = w_p;
      MODE_FALL: w_shape = ~w_p;
      MODE_TRI:  w_shape = w_p[OUT_W-1] ? ~w_p_dbl : w_p_dbl;
      MODE_SQR:  w_shape = (w_p < r_act.duty) ? '1 : '0;
      default:   w_shape = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wave  <= '0;
      r_valid <= 1'b0;
    end else if (r_en_d) begin
      r_wave  <= w_shape;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign wave_out   = r_wave;
  assign wave_valid = r_valid;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_wave_dds_gen.sv
// Randomized check of wave_dds_gen against an arithmetic reference model.
module tb_wave_dds_gen;
  localparam int PW = 16;
  localparam int OW = 8;
  localparam int PMOD = 1 << PW;
  localparam int OMAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, sync, load;
  logic [PW-1:0] tune_word;
  logic [1:0]    mode;
  logic [OW-1:0] duty;
  logic [OW-1:0] wave_out;
  logic          wave_valid, wrap;

  int total = 0;
  int bad   = 0;

  wave_dds_gen #(.PHASE_W(PW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .load(load),
    .tune_word(tune_word), .mode(mode), .duty(duty),
    .wave_out(wave_out), .wave_valid(wave_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // reference state
  int m_acc, m_tune, m_mode, m_duty;
  int p_tune, p_mode, p_duty;
  bit m_pend, m_wrap, m_valid, m_en_prev;
  int m_wave;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int shape(input int acc, input int md, input int dt);
    int p;
    p = acc / (1 << (PW - OW));
    case (md)
      0: return p;
      1: return OMAX - p;
      2: return (p < 128) ? 2 * p : OMAX - 2 * (p - 128);
      default: return (p < dt) ? OMAX : 0;
    endcase
  endfunction

  task automatic model_edge();
    int sum;
    bit c, apply;
    if (rst) begin
      m_acc = 0; m_tune = 0; m_mode = 0; m_duty = 1 << (OW - 1);
      m_pend = 0; m_wave = 0; m_valid = 0; m_wrap = 0; m_en_prev = 0;
      return;
    end
    if (m_en_prev) begin
      m_wave  = shape(m_acc, m_mode, m_duty);
      m_valid = 1;
    end else m_valid = 0;
    sum   = m_acc + m_tune;
    c     = en && !sync && (sum >= PMOD);
    apply = sync || c;
    if (sync) m_acc = 0;
    else if (en) m_acc = sum % PMOD;
    m_wrap = c;
    if (load) begin
      if (!en || apply) begin
        m_tune = tune_word; m_mode = mode; m_duty = duty; m_pend = 0;
      end else begin
        p_tune = tune_word; p_mode = mode; p_duty = duty; m_pend = 1;
      end
    end else if (apply && m_pend) begin
      m_tune = p_tune; m_mode = p_mode; m_duty = p_duty; m_pend = 0;
    end
    m_en_prev = en;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("wave_out", 32'(wave_out), 32'(m_wave));
    chk("wave_valid", 32'(wave_valid), 32'(m_valid));
    chk("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic idle();
    rst = 0; en = 0; sync = 0; load = 0;
  endtask

  int wraps;

  initial begin
    idle();
    tune_word = '0; mode = '0; duty = '0;
    rst = 1; load = 1; en = 1; sync = 1; tune_word = 16'h1234;
    step();
    idle();

    // saw at 0x0100: one wrap in every 256 enabled edges
    load = 1; tune_word = 16'h0100; mode = 2'b00;
    step();
    load = 0; en = 1;
    wraps = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (wrap) wraps++;
    end
    chk("wrap_count", 32'(wraps), 32'd1);

    // triangle and square sweeps, loaded with en=0
    idle(); load = 1; mode = 2'b10; tune_word = 16'h0100; step();
    load = 0; en = 1; for (int i = 0; i < 260; i++) step();
    idle(); load = 1; mode = 2'b11; duty = 8'h40; step();
    load = 0; en = 1; for (int i = 0; i < 260; i++) step();

    // pending load while running, taken at the next wrap
    load = 1; tune_word = 16'h0200; mode = 2'b01; step();
    load = 0; for (int i = 0; i < 300; i++) step();

    // sync with pending config, then rst with pending
    load = 1; tune_word = 16'h0700; mode = 2'b10; step();
    load = 0; sync = 1; step(); sync = 0;
    load = 1; tune_word = 16'h0300; step(); load = 0; step();
    rst = 1; step(); rst = 0; for (int i = 0; i < 20; i++) step();
    chk("post_rst_wave", 32'(wave_out), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: tune_word = PW'($urandom);
        1: tune_word = '0;
        2: tune_word = 16'h0100;
        default: tune_word = PW'($urandom_range(0, 4095));
      endcase
      mode = 2'($urandom);
      duty = OW'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
